bypass_fifo: RTL and testbench
==============================

Name: bypass_fifo

Overview:
Parametrised-depth FIFO with a zero-latency combinational bypass path. It generalises the single-entry bypass buffer to DEPTH entries and adds an occupancy output. When storage is empty, written data is presented on read_data in the same cycle. When storage is full, a same-cycle read frees space for a write. Used as a low-latency elastic stage between read/write-enable producers and consumers.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of storage entries (>=2, any integer, not restricted to a power of two)

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset; sampled on the rising clock edge
write_enable  input  1  push write_data this cycle
write_data  input  WIDTH  data to push
full  output  1  write not accepted this cycle
read_enable  input  1  pop read_data this cycle
read_data  output  WIDTH  head data; equals write_data when bypassing
empty  output  1  no data available this cycle
level  output  $clog2(DEPTH+1)  number of stored entries; bypassed words are not counted

Behaviour:
- Reset (synchronous, active-high):
  - Read and write pointers and count are set to 0.
  - After reset: level=0, full=0, empty=1 when write_enable=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all stored data at that edge. Any read or write in the same cycle has no effect.
- Internal state:
  - Circular storage array of DEPTH entries.
  - Write and read pointers, each 0..DEPTH-1, wrapping from DEPTH-1 to 0 explicitly. Non-power-of-two DEPTH is supported.
  - Count, 0..DEPTH.
- Combinational outputs:
  - empty = (count==0) && !write_enable
  - full = (count==DEPTH) && !read_enable
  - read_data = storage[read pointer] if count>0, else write_data (bypass)
  - level = count
- Cycle cases (active cycle, reset low):
  - count==0, write and read: bypass. Data passes straight through in 0 cycles. Count, pointers and storage are unchanged.
  - count==0, write only: storage[write pointer] <= write_data, write pointer advances, count +1.
  - count==DEPTH, write and read: head popped and new word stored in the same edge. Both pointers advance, count unchanged (stays DEPTH).
  - 0<count<DEPTH, write and read: both pointers advance, count unchanged.
  - Write only, count<DEPTH: store and advance write pointer, count +1.
  - Read only, count>0: advance read pointer, count -1.
- Read latency: 0 cycles via bypass when empty; otherwise data is visible on read_data the cycle after the write edge.
- Throughput: one transfer per cycle in every state, including sustained simultaneous read and write at count 0 and at count DEPTH.
- Illegal operations (state unchanged):
  - Write while full (count==DEPTH and read_enable=0): data dropped.
  - Read while empty (count==0 and write_enable=0): read_data is don't-care.
- Integration constraint: full depends on read_enable, and empty depends on write_enable. Integrators must not form a combinational loop (for example read_enable derived from empty while write_enable is derived from full).

Optional Feature:
Macro: BYPASS_FIFO_ERROR_FLAGS_EN
- Defined:
  - Adds output ports overflow (1 bit) and underflow (1 bit).
  - overflow is set on any edge where a write while full occurs.
  - underflow is set on any edge where a read while empty occurs.
  - Both are sticky until reset and reset to 0.
  - A flag becomes visible the cycle after the offending edge.
- Undefined: the ports and their logic are absent. Illegal operations are silently ignored as described above.

Test Plan:
1. Reset, then write_enable=1, read_enable=1, write_data=0xAA with the FIFO empty -> read_data=0xAA in the same cycle, empty=0, full=0; next cycle level=0, empty=1.
2. DEPTH=4: write 0x01,0x02,0x03,0x04 with no reads -> level steps 1,2,3,4; after the 4th edge full=1, empty=0. A 5th write (0x05) with no read -> dropped; level stays 4.
3. Full FIFO from test 2: read_enable=1 and write_enable=1 with 0x10..0x1F for 16 cycles -> full=0 while reading, level stays 4. read_data sequence = 0x01..0x04 then 0x10..0x1B.
4. Wrap-around with DEPTH=3 (non-power-of-two): 10 rounds of write 2 / read 2 with values 0..19 -> read order 0..19 exact, no loss; empty=1 at the end.
5. Reset mid-operation at level=3 with write_enable=1 in the reset cycle -> next cycle level=0, empty=1 with write_enable=0, full=0, no stored data surfaces.
6. Random: write and read probability 0.5 each, respecting full and empty; 1000 transfers compared against a scoreboard queue, with a 10000-cycle timeout -> zero mismatches. With BYPASS_FIFO_ERROR_FLAGS_EN defined: one forced write while full -> overflow=1 the next cycle and held until reset.

Source files
------------

// File: rtl/bypass_fifo.sv
// bypass_fifo: DEPTH-entry circular FIFO with a zero-latency combinational
// bypass. When nothing is stored, write_data is presented on read_data in
// the same cycle. A simultaneous read and write on a full FIFO is accepted.
//
// Optional build macro: BYPASS_FIFO_ERROR_FLAGS_EN adds the sticky overflow
// and underflow flags.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   write_enable  push write_data this cycle
//   write_data    data to push (WIDTH bits)
//   full          write not accepted this cycle
//   read_enable   pop read_data this cycle
//   read_data     head data, or write_data when bypassing
//   empty         no data available this cycle
//   level         number of stored entries; bypassed words are not counted
//   overflow      (macro only) sticky: a write was attempted while full
//   underflow     (macro only) sticky: a read was attempted while empty
module bypass_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       write_enable,
    input  logic [WIDTH-1:0]           write_data,
    output logic                       full,
    input  logic                       read_enable,
    output logic [WIDTH-1:0]           read_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
    ,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_store_empty;
    logic             w_store_full;
    logic             w_bypass;
    logic             w_do_write;
    logic             w_do_read;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;

    always_comb begin
        w_store_empty = (r_count == '0);
        w_store_full  = (r_count == CNT_W'(DEPTH));

        // A write+read with nothing stored passes straight through and
        // leaves all state untouched.
        w_bypass   = w_store_empty && write_enable && read_enable;
        // On a full FIFO the same-edge read frees the slot the write takes.
        w_do_write = write_enable && !w_bypass && (!w_store_full || read_enable);
        w_do_read  = read_enable && !w_store_empty;

        // Explicit wrap so non-power-of-two depths work.
        w_wr_ptr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
        w_rd_ptr_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

        empty     = w_store_empty && !write_enable;
        full      = w_store_full && !read_enable;
        read_data = w_store_empty ? write_data : r_mem[r_rd_ptr];
        level     = r_count;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_write) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_do_read) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            case ({w_do_write, w_do_read})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (!reset && w_do_write) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write_enable && w_store_full && !read_enable) begin
                r_overflow <= 1'b1;
            end
            if (read_enable && w_store_empty && !write_enable) begin
                r_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        overflow  = r_overflow;
        underflow = r_underflow;
    end
`endif

endmodule

// File: tb/tb_bypass_fifo.sv
// Scoreboard bench for bypass_fifo: a DEPTH=4 instance (directed + random)
// and a DEPTH=3 instance (wrap-around). Stimulus pushes accepted write data
// into a per-instance queue; a monitor per instance pops and compares on
// every read transfer. Flags and level are checked against a count model.
module tb_bypass_fifo;

    localparam int DA = 4;
    localparam int DB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic       we    [2];
    logic       re    [2];
    logic       full  [2];
    logic       empty [2];
    logic [7:0] wd    [2];
    logic [7:0] rd    [2];
    logic [2:0] lvl_a;
    logic [1:0] lvl_b;
`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
    logic ovf_a, unf_a, ovf_b, unf_b;
`endif

    int checks = 0;
    int errors = 0;
    int mcount [2];
    int rd_xfers = 0;
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] ea, eb;

    bypass_fifo #(.WIDTH(8), .DEPTH(DA)) u_a (
        .clock(clk), .reset(rst[0]),
        .write_enable(we[0]), .write_data(wd[0]), .full(full[0]),
        .read_enable(re[0]), .read_data(rd[0]), .empty(empty[0]),
        .level(lvl_a)
`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
        , .overflow(ovf_a), .underflow(unf_a)
`endif
    );

    bypass_fifo #(.WIDTH(8), .DEPTH(DB)) u_b (
        .clock(clk), .reset(rst[1]),
        .write_enable(we[1]), .write_data(wd[1]), .full(full[1]),
        .read_enable(re[1]), .read_data(rd[1]), .empty(empty[1]),
        .level(lvl_b)
`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
        , .overflow(ovf_b), .underflow(unf_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus on instance k; flags/level checked against the
    // pre-edge model count, then the model is advanced.
    task automatic cyc(input int k, input logic w, input logic r, input logic [7:0] d);
        int   dep;
        logic wok, rok;
        dep = (k == 0) ? DA : DB;
        @(posedge clk);
        #1;
        we[k] = w; re[k] = r; wd[k] = d;
        #2;
        check($sformatf("empty%0d", k), 32'(empty[k]), 32'(mcount[k] == 0 && !w));
        check($sformatf("full%0d", k), 32'(full[k]), 32'(mcount[k] == dep && !r));
        check($sformatf("level%0d", k), (k == 0) ? 32'(lvl_a) : 32'(lvl_b), 32'(mcount[k]));
        wok = w && (mcount[k] < dep || r);
        rok = r && (mcount[k] > 0 || w);
        if (wok) begin
            if (k == 0) qa.push_back(d);
            else        qb.push_back(d);
        end
        if (rok && k == 0) rd_xfers++;
        mcount[k] = mcount[k] + int'(wok) - int'(rok);
    endtask

    task automatic do_reset(input int k, input logic w);
        @(posedge clk);
        #1;
        rst[k] = 1'b1; we[k] = w; re[k] = 1'b0; wd[k] = 8'hEE;
        @(posedge clk);
        #1;
        rst[k] = 1'b0; we[k] = 1'b0;
        mcount[k] = 0;
        if (k == 0) qa.delete();
        else        qb.delete();
    endtask

`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
    task automatic check_flags_a(input string name, input logic o, input logic u);
        @(posedge clk);
        #1;
        we[0] = 1'b0; re[0] = 1'b0;
        check({name, "_ovf"}, 32'(ovf_a), 32'(o));
        check({name, "_unf"}, 32'(unf_a), 32'(u));
    endtask
`endif

    always @(negedge clk) begin
        if (!rst[0] && re[0] && !empty[0]) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_a: got %0h expected no read (scoreboard empty)", rd[0]);
            end else begin
                ea = qa.pop_front();
                check("rd_a", 32'(rd[0]), 32'(ea));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst[1] && re[1] && !empty[1]) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_b: got %0h expected no read (scoreboard empty)", rd[1]);
            end else begin
                eb = qb.pop_front();
                check("rd_b", 32'(rd[1]), 32'(eb));
            end
        end
    end

    initial begin
        int   cycles;
        logic w, r;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; we[k] = 1'b0; re[k] = 1'b0; wd[k] = '0; mcount[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Reset state, then bypass at count 0
        cyc(0, 0, 0, 8'h00);
        cyc(0, 1, 1, 8'hAA);
        cyc(0, 0, 0, 8'h00);

        // Fill to DEPTH, then a dropped write while full
        for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 8'(i));
        cyc(0, 1, 0, 8'h05);
`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
        check_flags_a("after_full_write", 1'b1, 1'b0);
`endif

        // Sustained read+write at full
        for (int i = 0; i < 16; i++) cyc(0, 1, 1, 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // Reset at level 3 with a write in the reset cycle
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'(8'hC0 + i));
        do_reset(0, 1'b1);
        cyc(0, 0, 0, 8'h00);
`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
        check({"post_reset", "_ovf"}, 32'(ovf_a), 32'(1'b0));
        check({"post_reset", "_unf"}, 32'(unf_a), 32'(1'b0));
`endif
        cyc(0, 1, 0, 8'h5A);
        cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // Wrap-around on the DEPTH=3 instance
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 8'(2 * i));
            cyc(1, 1, 0, 8'(2 * i + 1));
            cyc(1, 0, 1, 8'h00);
            cyc(1, 0, 1, 8'h00);
        end
        cyc(1, 0, 0, 8'h00);
        check("b_drained", 32'(qb.size()), 32'd0);

        // Random traffic respecting full/empty
        rd_xfers = 0;
        cycles = 0;
        while (rd_xfers < 1000 && cycles < 10000) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (w && mcount[0] == DA && !r) w = 1'b0;
            if (r && mcount[0] == 0 && !w) r = 1'b0;
            cyc(0, w, r, 8'($urandom));
            cycles++;
        end
        check("rand_transfers_done", 32'(rd_xfers >= 1000), 32'd1);

`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
        do_reset(0, 1'b0);
        check_flags_a("clean", 1'b0, 1'b0);
        while (mcount[0] < DA) cyc(0, 1, 0, 8'($urandom));
        cyc(0, 1, 0, 8'h77);
        check_flags_a("forced_ovf", 1'b1, 1'b0);
        check_flags_a("ovf_held", 1'b1, 1'b0);
        cyc(0, 0, 1, 8'h00);
        check_flags_a("ovf_sticky", 1'b1, 1'b0);
        do_reset(0, 1'b0);
        check_flags_a("ovf_cleared", 1'b0, 1'b0);
        cyc(0, 0, 1, 8'h00);
        check_flags_a("forced_unf", 1'b0, 1'b1);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
